param_tensor_core: RTL and testbench

Parametrised successor to the 3×3 tensor core. It performs a signed DIM×DIM matrix multiply, multiply-accumulate, element-wise add or ReLU, computing LANES output elements per cycle. Operands and the opcode are latched at start, so the inputs may change while the block is busy. A start/busy/done handshake and a registered result bank let the register file and controller drive it without tracking cycles.

---
 rtl/tensor_core_pkg.sv | 41 ++++
 rtl/tensor_core_lane.sv | 45 ++++
 rtl/param_tensor_core.sv | 122 ++++++++++++
 tb/tb_param_tensor_core.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tensor_core_pkg.sv
// Shared types and the result-width reduction for param_tensor_core.
// Define TENSOR_CORE_SATURATE_EN to clamp results; otherwise they wrap.
package tensor_core_pkg;

    typedef enum logic [1:0] {
        MATMUL = 2'b00,
        ADD    = 2'b01,
        RELU   = 2'b10,
        MAC    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_e;

    localparam int RED_W = 64;

    // Caller keeps only the low data_w bits of the returned value.
    function automatic logic signed [RED_W-1:0] reduce_to_data_w(
        input logic signed [RED_W-1:0] value,
        input int                      data_w
    );
`ifdef TENSOR_CORE_SATURATE_EN
        logic signed [RED_W-1:0] max_v;
        logic signed [RED_W-1:0] min_v;
        max_v = (RED_W'(1) <<< (data_w - 1)) - RED_W'(1);
        min_v = -max_v - RED_W'(1);
        if (value > max_v)
            return max_v;
        else if (value < min_v)
            return min_v;
        else
            return value;
`else
        return (value <<< (RED_W - data_w)) >>> (RED_W - data_w);
`endif
    endfunction

endpackage

// File: rtl/tensor_core_lane.sv
// One result element: dot product, MAC, add or ReLU, reduced to DATA_W.
// Reduction mode follows TENSOR_CORE_SATURATE_EN via the package function.
module tensor_core_lane
    import tensor_core_pkg::*;
#(
    parameter int DIM    = 3,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W + $clog2(DIM) + 1
) (
    input  logic signed [DATA_W-1:0] a_row [DIM],
    input  logic signed [DATA_W-1:0] b_col [DIM],
    input  logic signed [DATA_W-1:0] a_elem,
    input  logic signed [DATA_W-1:0] b_elem,
    input  logic signed [DATA_W-1:0] acc_elem,
    input  op_e                      op,
    output logic signed [DATA_W-1:0] result
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    dot;
    logic signed [ACC_W-1:0]    value;
    logic signed [RED_W-1:0]    reduced;

    always_comb begin
        prod = '0;
        dot  = '0;
        for (int unsigned k = 0; k < DIM; k++) begin
            prod = (2*DATA_W)'(a_row[k]) * (2*DATA_W)'(b_col[k]);
            dot  = dot + ACC_W'(prod);
        end

        value = dot;
        case (op)
            MATMUL:  value = dot;
            MAC:     value = dot + ACC_W'(acc_elem);
            ADD:     value = ACC_W'(a_elem) + ACC_W'(b_elem);
            RELU:    value = a_elem[DATA_W-1] ? '0 : ACC_W'(a_elem);
            default: value = dot;
        endcase

        reduced = reduce_to_data_w(RED_W'(value), DATA_W);
        result  = reduced[DATA_W-1:0];
    end

endmodule

// File: rtl/param_tensor_core.sv
// Parametrised DIMxDIM tensor core: FSM, operand latches, result bank, LANES lanes.
// Result reduction saturates when TENSOR_CORE_SATURATE_EN is defined, else wraps.
module param_tensor_core
    import tensor_core_pkg::*;
#(
    parameter int DIM    = 3,
    parameter int DATA_W = 8,
    parameter int LANES  = 1
) (
    input  logic                     tensor_core_clock,
    input  logic                     reset_in,
    input  logic                     start,
    input  logic [1:0]               operation_select,
    input  logic signed [DATA_W-1:0] tensor_core_input1 [DIM][DIM],
    input  logic signed [DATA_W-1:0] tensor_core_input2 [DIM][DIM],
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] tensor_core_output [DIM][DIM]
);

    localparam int ACC_W = 2*DATA_W + $clog2(DIM) + 1;
    localparam int N     = DIM * DIM;
    localparam int IDX_W = $clog2(N + LANES) + 1;
    localparam int RC_W  = $clog2(DIM);

    state_e                   state;
    op_e                      op_q;
    logic [IDX_W-1:0]         idx_q;
    logic signed [DATA_W-1:0] a_q [DIM][DIM];
    logic signed [DATA_W-1:0] b_q [DIM][DIM];

    logic                     lane_valid [LANES];
    logic [RC_W-1:0]          lane_row   [LANES];
    logic [RC_W-1:0]          lane_col   [LANES];
    logic signed [DATA_W-1:0] lane_out   [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IDX_W-1:0]         e;
        logic signed [DATA_W-1:0] a_row [DIM];
        logic signed [DATA_W-1:0] b_col [DIM];

        // Out-of-range lanes are steered to element 0 and masked from writing.
        assign e             = idx_q + IDX_W'(l);
        assign lane_valid[l] = (e < IDX_W'(N));
        assign lane_row[l]   = lane_valid[l] ? RC_W'(e / IDX_W'(DIM)) : '0;
        assign lane_col[l]   = lane_valid[l] ? RC_W'(e % IDX_W'(DIM)) : '0;

        always_comb begin
            for (int unsigned k = 0; k < DIM; k++) begin
                a_row[k] = a_q[lane_row[l]][k];
                b_col[k] = b_q[k][lane_col[l]];
            end
        end

        tensor_core_lane #(
            .DIM    (DIM),
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .a_row    (a_row),
            .b_col    (b_col),
            .a_elem   (a_q[lane_row[l]][lane_col[l]]),
            .b_elem   (b_q[lane_row[l]][lane_col[l]]),
            .acc_elem (tensor_core_output[lane_row[l]][lane_col[l]]),
            .op       (op_q),
            .result   (lane_out[l])
        );
    end

    always_ff @(posedge tensor_core_clock) begin
        if (reset_in) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            idx_q <= '0;
            op_q  <= MATMUL;
            for (int unsigned r = 0; r < DIM; r++) begin
                for (int unsigned c = 0; c < DIM; c++) begin
                    a_q[r][c]                <= '0;
                    b_q[r][c]                <= '0;
                    tensor_core_output[r][c] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= tensor_core_input1;
                        b_q   <= tensor_core_input2;
                        op_q  <= op_e'(operation_select);
                        idx_q <= '0;
                        busy  <= 1'b1;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        if (lane_valid[l])
                            tensor_core_output[lane_row[l]][lane_col[l]] <= lane_out[l];
                    end
                    idx_q <= idx_q + IDX_W'(LANES);
                    if (32'(idx_q) + 32'(LANES) >= 32'(N)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_tensor_core.sv
// Table-driven bench for param_tensor_core (DIM=3) with LANES=1 and LANES=4 instances.
// Expected values follow TENSOR_CORE_SATURATE_EN when it is defined.
module tb_param_tensor_core;

    logic                    clk = 1'b0;
    logic                    reset_in;
    logic                    start;
    logic                    start2;
    logic [1:0]              op_sel;
    logic signed [7:0]       in1  [3][3];
    logic signed [7:0]       in2  [3][3];
    logic signed [7:0]       out1 [3][3];
    logic signed [7:0]       out2 [3][3];
    logic                    busy, done, busy2, done2;

    int checks = 0;
    int errors = 0;

`ifdef TENSOR_CORE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    always #5 clk = ~clk;

    param_tensor_core dut (
        .tensor_core_clock  (clk),
        .reset_in           (reset_in),
        .start              (start),
        .operation_select   (op_sel),
        .tensor_core_input1 (in1),
        .tensor_core_input2 (in2),
        .busy               (busy),
        .done               (done),
        .tensor_core_output (out1)
    );

    param_tensor_core #(
        .DIM    (3),
        .DATA_W (8),
        .LANES  (4)
    ) dut4 (
        .tensor_core_clock  (clk),
        .reset_in           (reset_in),
        .start              (start2),
        .operation_select   (op_sel),
        .tensor_core_input1 (in1),
        .tensor_core_input2 (in2),
        .busy               (busy2),
        .done               (done2),
        .tensor_core_output (out2)
    );

    typedef struct {
        logic [1:0] op;
        int         a [9];
        int         b [9];
        int         exp_wrap [9];
        int         exp_sat  [9];
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input int a [9], input int b [9], input logic [1:0] op);
        for (int i = 0; i < 9; i++) begin
            in1[i/3][i%3] = 8'(a[i]);
            in2[i/3][i%3] = 8'(b[i]);
        end
        op_sel = op;
    endtask

    task automatic chk_result(input string name, input int exp [9]);
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s e%0d", name, i), int'(out1[i/3][i%3]), exp[i]);
    endtask

    // Start sampled at edge k; busy/done observed 1ns after edges k..k+10.
    task automatic run_vec(input int vi);
        load(vecs[vi].a, vecs[vi].b, vecs[vi].op);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j <= 9; j++) begin
            chk($sformatf("v%0d busy c%0d", vi, j), int'(busy), 1);
            chk($sformatf("v%0d done c%0d", vi, j), int'(done), (j == 9) ? 1 : 0);
            @(posedge clk); #1;
        end
        chk($sformatf("v%0d busy end", vi), int'(busy), 0);
        chk($sformatf("v%0d done end", vi), int'(done), 0);
        chk_result($sformatf("v%0d", vi), SAT ? vecs[vi].exp_sat : vecs[vi].exp_wrap);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ident [9];
        int seq   [9];
        int neg1  [9];
        int seq_exp [9];

        ident   = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        seq     = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        seq_exp = seq;

        vecs[0].op = 2'b00; vecs[0].a = ident; vecs[0].b = seq;
        vecs[0].exp_wrap = seq; vecs[0].exp_sat = seq;

        vecs[1].op = 2'b11; vecs[1].a = ident; vecs[1].b = seq;
        vecs[1].exp_wrap = '{2, 4, 6, 8, 10, 12, 14, 16, 18};
        vecs[1].exp_sat  = '{2, 4, 6, 8, 10, 12, 14, 16, 18};

        vecs[2].op = 2'b00; vecs[2].a = seq; vecs[2].b = seq;
        vecs[2].exp_wrap = '{30, 36, 42, 66, 81, 96, 102, 126, -106};
        vecs[2].exp_sat  = '{30, 36, 42, 66, 81, 96, 102, 126, 127};

        vecs[3].op = 2'b01;
        vecs[3].a = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
        vecs[3].b = vecs[3].a;
        vecs[3].exp_wrap = '{-56, -56, -56, -56, -56, -56, -56, -56, -56};
        vecs[3].exp_sat  = '{127, 127, 127, 127, 127, 127, 127, 127, 127};

        vecs[4].op = 2'b00;
        vecs[4].a = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
        vecs[4].b = vecs[4].a;
        vecs[4].exp_wrap = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[4].exp_sat  = '{127, 127, 127, 127, 127, 127, 127, 127, 127};

        vecs[5].op = 2'b01;
        vecs[5].a = '{-100, -100, -100, -100, -100, -100, -100, -100, -100};
        vecs[5].b = vecs[5].a;
        vecs[5].exp_wrap = '{56, 56, 56, 56, 56, 56, 56, 56, 56};
        vecs[5].exp_sat  = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};

        vecs[6].op = 2'b10;
        vecs[6].a = '{-1, 2, -3, 4, -5, 6, -7, 8, -128};
        vecs[6].b = '{55, 55, 55, 55, 55, 55, 55, 55, 55};
        vecs[6].exp_wrap = '{0, 2, 0, 4, 0, 6, 0, 8, 0};
        vecs[6].exp_sat  = '{0, 2, 0, 4, 0, 6, 0, 8, 0};

        // MAC on top of the ReLU result: A*I + previous
        vecs[7].op = 2'b11; vecs[7].a = seq; vecs[7].b = ident;
        vecs[7].exp_wrap = '{1, 4, 3, 8, 5, 12, 7, 16, 9};
        vecs[7].exp_sat  = '{1, 4, 3, 8, 5, 12, 7, 16, 9};

        // Reset with start asserted: reset wins.
        reset_in = 1'b1;
        start    = 1'b1;
        start2   = 1'b0;
        load(seq, seq, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk_result("reset", '{0, 0, 0, 0, 0, 0, 0, 0, 0});
        reset_in = 1'b0;
        start    = 1'b0;
        @(posedge clk); #1;
        chk("idle busy", int'(busy), 0);

        for (int v = 0; v < 8; v++)
            run_vec(v);

        // Four lanes: 3 compute cycles, element 8 written alone in the third.
        load(ident, seq, 2'b00);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("l4 busy c0", int'(busy2), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++)
            chk($sformatf("l4 early e%0d", i), int'(out2[i/3][i%3]), seq_exp[i]);
        chk("l4 e8 pending", int'(out2[2][2]), 0);
        chk("l4 done early", int'(done2), 0);
        @(posedge clk); #1;
        chk("l4 done c3", int'(done2), 1);
        chk("l4 e8", int'(out2[2][2]), 9);
        @(posedge clk); #1;
        chk("l4 busy end", int'(busy2), 0);
        chk("l4 done end", int'(done2), 0);

        // Start and input changes while busy are ignored.
        neg1 = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
        load(ident, seq, 2'b00);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j <= 9; j++) begin
            if (j == 3) begin
                load(neg1, neg1, 2'b01);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            chk($sformatf("ign done c%0d", j), int'(done), (j == 9) ? 1 : 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("ign busy end", int'(busy), 0);
        chk_result("ign", seq_exp);

        // Reset mid-compute aborts: no done, bank cleared.
        load(seq, seq, 2'b00);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort busy pre", int'(busy), 1);
        reset_in = 1'b1;
        @(posedge clk); #1;
        reset_in = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk_result("abort", '{0, 0, 0, 0, 0, 0, 0, 0, 0});
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            chk($sformatf("abort no done c%0d", j), int'(done), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
